spi_eeprom_slave: RTL and testbench

SPI mode-0 responder that emulates a 128-byte serial EEPROM, sitting on the far end of the SPI master's mosi/miso/csn link. It supports six commands: WREN, WRDI, RDSR, WRSR, READ and WRITE. The bench and the FPGA loopback build use it as the memory target for that master. Pins are oversampled in the clk domain, so no SCK clock domain exists.

---
 rtl/spi_eeprom_slave.sv | 213 +++++++++++++++++++++
 tb/tb_spi_eeprom_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_eeprom_slave.sv
// rtl/spi_eeprom_slave.sv - SPI mode-0 128-byte serial EEPROM responder, pins oversampled in clk.
module spi_eeprom_slave #(
  parameter int WRITE_CYCLES = 1000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  localparam int CNT_W = $clog2(WRITE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_RD_DATA, ST_WR_DATA, ST_RDSR, ST_WRSR, ST_IGNORE
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic sck_s, csn_s, mosi_s, sck_d, csn_d, armed;
  logic sck_rise, sck_fall, csn_rise, csn_fall, byte_done;

  logic [2:0]       bit_cnt;
  logic [7:0]       shift, tx_shift, rx_byte, tx_load;
  logic [6:0]       addr;
  logic             op_wr, got_data;
  logic             wel, wip;
  logic [1:0]       bp, bp_pend;
  logic [CNT_W-1:0] busy_cnt;
  logic [7:0]       mem [128];
  logic [7:0]       pbuf [16];
  logic [15:0]      pbuf_valid;
  logic [7:0]       status;
  logic             out_state;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  // armed blocks a frame already in progress when reset was released
  assign csn_fall = armed & csn_d & ~csn_s;
  assign csn_rise = armed & csn_s & ~csn_d;

  assign rx_byte   = {shift[6:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
  assign status    = {4'b0000, bp, wel, wip};
  assign out_state = (state == ST_RD_DATA) || (state == ST_RDSR);
  assign tx_load   = (state == ST_RDSR) ? status : mem[addr];

  assign miso_oe  = armed & ~csn_s;
  assign dbg_data = mem[dbg_addr];
  assign busy     = wip;

  function automatic logic is_prot(input logic [6:0] a, input logic [1:0] p);
    case (p)
      2'b01:   is_prot = (a[6:5] == 2'b11);
      2'b10:   is_prot = a[6];
      2'b11:   is_prot = 1'b1;
      default: is_prot = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      csn_sync  <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      csn_d     <= csn_s;
      if (csn_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (csn_rise) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (csn_fall) state_nx = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (wip && rx_byte != 8'h05) state_nx = ST_IGNORE;
            else begin
              case (rx_byte)
                8'h05:        state_nx = ST_RDSR;
                8'h01:        state_nx = ST_WRSR;
                8'h02, 8'h03: state_nx = ST_ADDR;
                default:      state_nx = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: if (byte_done) state_nx = op_wr ? ST_WR_DATA : ST_RD_DATA;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      tx_shift   <= '0;
      addr       <= '0;
      op_wr      <= 1'b0;
      got_data   <= 1'b0;
      wel        <= 1'b0;
      wip        <= 1'b0;
      bp         <= '0;
      bp_pend    <= '0;
      busy_cnt   <= '0;
      miso       <= 1'b0;
      pbuf_valid <= '0;
      for (int i = 0; i < 128; i++) mem[i] <= 8'hFF;
      for (int i = 0; i < 16; i++) pbuf[i] <= 8'h00;
    end else begin
      if (wip) begin
        if (busy_cnt <= CNT_W'(1)) begin
          wip      <= 1'b0;
          wel      <= 1'b0;
          busy_cnt <= '0;
        end else begin
          busy_cnt <= busy_cnt - CNT_W'(1);
        end
      end

      if (csn_fall) begin
        bit_cnt  <= '0;
        got_data <= 1'b0;
      end else if (sck_rise && state != ST_IDLE) begin
        shift   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        case (state)
          ST_CMD: begin
            op_wr <= (rx_byte == 8'h02);
            if (!wip && rx_byte == 8'h06) wel <= 1'b1;
            if (!wip && rx_byte == 8'h04) wel <= 1'b0;
          end
          ST_ADDR: addr <= rx_byte[6:0];
          ST_WR_DATA: begin
            pbuf[addr[3:0]]       <= rx_byte;
            pbuf_valid[addr[3:0]] <= 1'b1;
            addr[3:0]             <= addr[3:0] + 4'd1;
            got_data              <= 1'b1;
          end
          ST_WRSR: begin
            bp_pend  <= rx_byte[3:2];
            got_data <= 1'b1;
          end
          default: ;
        endcase
      end

      // bit_cnt==0 on a fall means the previous rise closed a byte: load the next one
      if (sck_fall) begin
        if (out_state && bit_cnt == 3'd0) begin
          miso     <= tx_load[7];
          tx_shift <= {tx_load[6:0], 1'b0};
          if (state == ST_RD_DATA) addr <= addr + 7'd1;
        end else if (out_state) begin
          miso     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end else begin
          miso <= 1'b0;
        end
      end

      if (csn_rise) begin
        miso       <= 1'b0;
        pbuf_valid <= '0;
        got_data   <= 1'b0;
        if ((state == ST_WR_DATA || state == ST_WRSR) && bit_cnt == 3'd0 && wel && got_data) begin
          wip      <= 1'b1;
          busy_cnt <= CNT_W'(WRITE_CYCLES);
          if (state == ST_WRSR) begin
            bp <= bp_pend;
          end else begin
            for (int i = 0; i < 16; i++) begin
              if (pbuf_valid[i] && !is_prot({addr[6:4], 4'(i)}, bp))
                mem[{addr[6:4], 4'(i)}] <= pbuf[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// tb/tb_spi_eeprom_slave.sv - table, directed and random checks of spi_eeprom_slave against a byte-level model.
module tb_spi_eeprom_slave;

  localparam int W  = 300;
  localparam int HB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, busy;
  logic [6:0] dbg_addr = 7'd0;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  spi_eeprom_slave #(.WRITE_CYCLES(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] m_mem [128];
  logic       m_wel, m_wip;
  logic [1:0] m_bp;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] wq[$];

  int run_len = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (busy) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] exp_sr;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_sr();
    return {4'b0000, m_bp, m_wel, m_wip};
  endfunction

  function automatic bit m_prot(input int a);
    if (m_bp == 2'd1) return a >= 96;
    if (m_bp == 2'd2) return a >= 64;
    return m_bp == 2'd3;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'hFF;
    m_wel = 1'b0;
    m_wip = 1'b0;
    m_bp  = 2'd0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      clks(HB);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      clks(HB);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int last_bits);
    logic [7:0] r;
    rxq.delete();
    csn = 1'b0;
    clks(HB);
    for (int i = 0; i < txq.size(); i++) begin
      spi_bits(txq[i], (i == txq.size() - 1) ? last_bits : 8, r);
      rxq.push_back(r);
    end
    clks(HB);
    csn = 1'b1;
    clks(6);
  endtask

  task automatic do_simple(input logic [7:0] op);
    txq = '{op};
    run_frame(8);
    if (!m_wip && op == 8'h06) m_wel = 1'b1;
    if (!m_wip && op == 8'h04) m_wel = 1'b0;
  endtask

  task automatic do_rdsr(input int n);
    txq = '{8'h05};
    for (int i = 0; i < n; i++) txq.push_back(8'h00);
    run_frame(8);
    for (int i = 0; i < n; i++) check("rdsr_byte", rxq[1+i], m_sr());
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    txq = '{8'h03, {1'b0, a}};
    for (int i = 0; i < n; i++) txq.push_back(8'h00);
    run_frame(8);
    for (int i = 0; i < n; i++)
      check("read_byte", rxq[2+i], m_wip ? 8'h00 : m_mem[(int'(a) + i) % 128]);
  endtask

  task automatic do_write(input logic [6:0] a, input int last_bits);
    logic [7:0] pb [16];
    bit         pv [16];
    int         slot, base;
    txq = '{8'h02, {$urandom_range(0, 1) ? 1'b1 : 1'b0, a}};
    foreach (wq[i]) txq.push_back(wq[i]);
    run_frame(last_bits);
    if (!m_wip && m_wel && last_bits == 8 && wq.size() > 0) begin
      for (int i = 0; i < 16; i++) pv[i] = 0;
      base = int'(a) & 'h70;
      slot = int'(a) % 16;
      foreach (wq[i]) begin
        pb[slot] = wq[i];
        pv[slot] = 1;
        slot = (slot + 1) % 16;
      end
      for (int i = 0; i < 16; i++)
        if (pv[i] && !m_prot(base + i)) m_mem[base + i] = pb[i];
      m_wip = 1'b1;
    end
    check("busy_after_write", busy, m_wip);
  endtask

  task automatic do_wrsr(input logic [7:0] v);
    txq = '{8'h01, v};
    run_frame(8);
    if (!m_wip && m_wel) begin
      m_bp  = v[3:2];
      m_wip = 1'b1;
    end
    check("busy_after_wrsr", busy, m_wip);
  endtask

  task automatic wait_done();
    if (m_wip) begin
      for (int i = 0; i < W + 50 && busy; i++) clks(1);
      check("wip_cleared", busy, 1'b0);
      clks(1);
      check("wip_length", last_run, W);
      m_wip = 1'b0;
      m_wel = 1'b0;
    end
    clks(4);
  endtask

  task automatic check_dbg(input logic [6:0] a);
    dbg_addr = a;
    #1;
    check("dbg_data", dbg_data, m_mem[a]);
  endtask

  initial begin
    logic [6:0] ra;
    m_reset();
    vt[0] = '{8'h05, 8'h00};
    vt[1] = '{8'h06, 8'h02};
    vt[2] = '{8'h04, 8'h00};
    vt[3] = '{8'h06, 8'h02};
    vt[4] = '{8'hAB, 8'h02};
    vt[5] = '{8'h04, 8'h00};

    clks(3);
    rst = 1'b0;
    clks(6);
    check("reset_miso", miso, 1'b0);
    check("reset_miso_oe", miso_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    dbg_addr = 7'h00;
    #1;
    check("reset_dbg", dbg_data, 8'hFF);

    csn = 1'b0;
    clks(HB);
    check("miso_oe_active", miso_oe, 1'b1);
    csn = 1'b1;
    clks(6);
    check("miso_oe_idle", miso_oe, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_simple(vt[i].op);
      txq = '{8'h05, 8'h00};
      run_frame(8);
      check("table_status", rxq[1], vt[i].exp_sr);
    end

    do_rdsr(2);

    do_simple(8'h06);
    wq = '{8'hA5};
    do_write(7'h05, 8);
    txq = '{8'h05, 8'h00};
    run_frame(8);
    check("rdsr_during_wip", rxq[1], 8'h03);
    wait_done();
    do_read(7'h05, 1);
    dbg_addr = 7'h05;
    #1;
    check("dbg_a5", dbg_data, 8'hA5);

    do_simple(8'h06);
    wq = '{8'h11, 8'h22, 8'h33};
    do_write(7'h0E, 8);
    do_read(7'h0E, 1);
    wait_done();
    do_read(7'h7F, 3);
    dbg_addr = 7'h00;
    #1;
    check("page_wrap", dbg_data, 8'h33);
    check_dbg(7'h0E);
    check_dbg(7'h0F);
    check_dbg(7'h10);

    do_simple(8'h04);
    wq = '{8'h77};
    do_write(7'h20, 8);
    check_dbg(7'h20);
    do_simple(8'h06);
    wq = '{8'h77};
    do_write(7'h20, 4);
    check_dbg(7'h20);
    txq = '{8'h05, 8'h00};
    run_frame(8);
    check("abort_keeps_wel", rxq[1], 8'h02);

    do_wrsr(8'h0C);
    wait_done();
    do_simple(8'h06);
    wq = '{8'h55};
    do_write(7'h10, 8);
    wait_done();
    dbg_addr = 7'h10;
    #1;
    check("bp11_protects", dbg_data, 8'hFF);
    txq = '{8'h05, 8'h00};
    run_frame(8);
    check("bp11_status", rxq[1], 8'h0C);
    do_simple(8'h06);
    do_wrsr(8'h00);
    wait_done();

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_simple(8'h06);
        do_wrsr(8'($urandom_range(0, 3) << 2));
        wait_done();
      end
      if ($urandom_range(0, 3) != 0) do_simple(8'h06);
      wq.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) wq.push_back(8'($urandom));
      do_write(7'($urandom), 8);
      wait_done();
      do_read(7'($urandom), int'($urandom_range(1, 4)));
      ra = 7'($urandom);
      check_dbg(ra);
    end

    do_simple(8'h06);
    wq = '{8'h99};
    do_write(7'h33, 8);
    check("busy_before_rst", busy, 1'b1);
    clks(20);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    m_reset();
    for (int i = 0; i < 128; i++) begin
      dbg_addr = 7'(i);
      #1;
      check("rst_array", dbg_data, 8'hFF);
    end
    clks(2);
    rst = 1'b0;
    clks(6);
    do_rdsr(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
